// File: rtl/uart_pkg.sv
// uart_pkg
// Definitions shared by the colour-sensor UART transmit path and its
// matching receiver uart_rx1:
//   - frame constants (bit period default, bits per frame, error character)
//   - tx_state_t, the transmit sequencing states
//   - even_parity(), the parity rule both ends of the link agree on
package uart_pkg;

    localparam int          CLKS_PER_BIT_DEF = 14;
    localparam int          FRAME_BITS       = 11;
    localparam logic [7:0]  PARITY_ERR_CHAR  = 8'h3F;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        GAP    = 3'd5
    } tx_state_t;

    // Parity bit that makes (data ones + parity) even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx1.sv
// uart_tx1
// Bit-level serializer: start bit, 8 data bits MSB first, even parity,
// stop bit, each held CLKS_PER_BIT cycles.
// Ports:
//   clk_3125   - system clock
//   rst_n      - asynchronous active-low reset
//   load       - take load_data and begin a frame (honoured only when ready)
//   load_data  - byte to transmit
//   ready      - serializer is idle and will accept load
//   tx         - serial line, idle high (registered)
//   frame_done - one-cycle pulse in the last cycle of the stop bit (registered)
module uart_tx1
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk_3125,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_data,
    output logic       ready,
    output logic       tx,
    output logic       frame_done
);

    localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    // frame_done is registered, so it is set one cycle before the last one.
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

    tx_state_t        state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic             parity_r;
    logic             tx_r;
    logic             frame_done_r;
    logic             bit_end_s;

    assign bit_end_s  = (cnt_r == CNT_LAST);
    assign ready      = (state_r == IDLE);
    assign tx         = tx_r;
    assign frame_done = frame_done_r;

    // Frame sequencer: bit timer, shift register and line driver.
    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            bit_idx_r    <= 3'd7;
            shift_r      <= 8'h00;
            parity_r     <= 1'b0;
            tx_r         <= 1'b1;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    cnt_r <= '0;
                    tx_r  <= 1'b1;
                    if (load) begin
                        shift_r   <= load_data;
                        parity_r  <= even_parity(load_data);
                        bit_idx_r <= 3'd7;
                        tx_r      <= 1'b0;
                        state_r   <= START;
                    end
                end
                START: begin
                    if (bit_end_s) begin
                        cnt_r     <= '0;
                        tx_r      <= shift_r[7];
                        shift_r   <= {shift_r[6:0], 1'b0};
                        bit_idx_r <= 3'd7;
                        state_r   <= DATA;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end_s) begin
                        cnt_r <= '0;
                        if (bit_idx_r == 3'd0) begin
                            tx_r    <= parity_r;
                            state_r <= PARITY;
                        end else begin
                            bit_idx_r <= bit_idx_r - 3'd1;
                            tx_r      <= shift_r[7];
                            shift_r   <= {shift_r[6:0], 1'b0};
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                PARITY: begin
                    if (bit_end_s) begin
                        cnt_r   <= '0;
                        tx_r    <= 1'b1;
                        state_r <= STOP;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end_s) begin
                        cnt_r   <= '0;
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                        if (cnt_r == CNT_PRE) begin
                            frame_done_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    cnt_r   <= '0;
                    tx_r    <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/color_tx_sched.sv
// color_tx_sched
// Round-robin transmit scheduler sharing one UART line among NREQ byte
// producers (R/G/B reporters, status source). Arbitrates in IDLE, hands
// the granted byte to uart_tx1 and holds the line idle for GAP_BITS
// bit-times after every stop bit.
// Ports:
//   clk_3125   - system clock (3.125 MHz)
//   rst_n      - asynchronous active-low reset
//   req        - per-requester byte valid, held until ack
//   req_data   - byte i at [8*i+7:8*i]
//   ack        - one-cycle pulse: byte i was latched
//   tx         - serial line, idle high
//   busy       - high from the ack cycle through the last gap cycle
//   grant_id   - index of the last granted requester
//   frame_done - one-cycle pulse in the last cycle of the stop bit
module color_tx_sched
    import uart_pkg::*;
#(
    parameter int NREQ         = 3,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int GAP_BITS     = 1
) (
    input  logic                      clk_3125,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req,
    input  logic [8*NREQ-1:0]         req_data,
    output logic [NREQ-1:0]           ack,
    output logic                      tx,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      frame_done
);

    localparam int GID_W     = $clog2(NREQ);
    localparam int GAP_CYC   = GAP_BITS * CLKS_PER_BIT;
    localparam int GAP_W     = $clog2(GAP_CYC + 2);
    localparam int GAP_LAST_I = (GAP_CYC > 0) ? (GAP_CYC - 1) : 0;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LAST_I);

    // START stands for "frame in flight": the serializer owns the
    // START/DATA/PARITY/STOP detail, this FSM only waits for its done pulse.
    tx_state_t         state_r;
    logic [NREQ-1:0]   ack_r;
    logic [GID_W-1:0]  grant_id_r;
    logic              busy_r;
    logic [GAP_W-1:0]  gap_cnt_r;

    logic              pick_valid_s;
    logic [GID_W-1:0]  pick_idx_s;
    logic [7:0]        pick_data_s;
    logic              load_s;
    logic              ser_ready_s;
    logic              ser_done_s;

    // Round-robin pick: first asserted request searching up from grant_id+1.
    always_comb begin
        pick_valid_s = 1'b0;
        pick_idx_s   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(grant_id_r) + k) % NREQ;
            if (!pick_valid_s && req[idx]) begin
                pick_valid_s = 1'b1;
                pick_idx_s   = GID_W'(idx);
            end else begin
                pick_valid_s = pick_valid_s;
            end
        end
    end

    assign pick_data_s = req_data[8*int'(pick_idx_s) +: 8];
    assign load_s      = (state_r == IDLE) && pick_valid_s && ser_ready_s;

    // Arbitration, ack/grant bookkeeping and inter-frame gap timer.
    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            ack_r      <= '0;
            grant_id_r <= GID_W'(NREQ - 1);
            busy_r     <= 1'b0;
            gap_cnt_r  <= '0;
        end else begin
            ack_r <= '0;
            case (state_r)
                IDLE: begin
                    gap_cnt_r <= '0;
                    if (load_s) begin
                        ack_r      <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx_s;
                        grant_id_r <= pick_idx_s;
                        busy_r     <= 1'b1;
                        state_r    <= START;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                START: begin
                    if (ser_done_s) begin
                        if (GAP_CYC == 0) begin
                            busy_r  <= 1'b0;
                            state_r <= IDLE;
                        end else begin
                            state_r <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt_r == GAP_LAST) begin
                        gap_cnt_r <= '0;
                        busy_r    <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GAP_W'(1);
                    end
                end
                default: begin
                    busy_r    <= 1'b0;
                    gap_cnt_r <= '0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    uart_tx1 #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clk_3125   (clk_3125),
        .rst_n      (rst_n),
        .load       (load_s),
        .load_data  (pick_data_s),
        .ready      (ser_ready_s),
        .tx         (tx),
        .frame_done (ser_done_s)
    );

    assign ack        = ack_r;
    assign busy       = busy_r;
    assign grant_id   = grant_id_r;
    assign frame_done = ser_done_s;

endmodule
